// File: rtl/mc_mem_access_unit.sv
// Memory-access sequencer: turns one-cycle fetch/load/store requests into MEM_LATENCY-cycle strobes on the instruction/data ports.
// Latency: request sampled at edge t0, strobe high cycles t0..t0+L-1, capture at edge t0+L, done pulse in cycle t0+L.
// Backpressure: requests are sampled only while idle (store > load > fetch); anything else, including requests during busy, is dropped.
//
// Ports:
//   clk, reset_n                          clock and synchronous active-low reset
//   fetch_req/fetch_addr                  instruction fetch request and PC
//   load_req/store_req/data_addr/store_data  data access request, address and store value
//   inst, mdr                             last fetched instruction / last loaded word
//   busy, done, num_fetch                 access in progress, completion pulse, completed-fetch count
//   readM1/address1/data1                 instruction memory port
//   readM2/writeM2/address2/data2         data memory port (data2 driven only while writing)
module mc_mem_access_unit #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  load_req,
  input  logic                  store_req,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [WORD_SIZE-1:0]  store_data,
  output logic [WORD_SIZE-1:0]  inst,
  output logic [WORD_SIZE-1:0]  mdr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  num_fetch,
  output logic                  readM1,
  output logic [ADDR_WIDTH-1:0] address1,
  input  logic [WORD_SIZE-1:0]  data1,
  output logic                  readM2,
  output logic                  writeM2,
  output logic [ADDR_WIDTH-1:0] address2,
  inout  wire  [WORD_SIZE-1:0]  data2
);

  // Latency is limited to 1..15, so a 4-bit down-counter is always enough.
  localparam int LAT_W = 4;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t               state;
  state_t               nextState;
  logic [LAT_W-1:0]     latCnt;
  logic [WORD_SIZE-1:0] storeData;
  logic                 accessDone;

  latencyRange: assert property (@(posedge clk) (MEM_LATENCY >= 1) && (MEM_LATENCY <= 15))
    else $error("mc_mem_access_unit: MEM_LATENCY must be within 1..15");

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    accessDone = 1'b0;
    case (state)
      IDLE: begin
        if (store_req) begin
          nextState = STORE;
        end else if (load_req) begin
          nextState = LOAD;
        end else if (fetch_req) begin
          nextState = FETCH;
        end
      end
      FETCH, LOAD, STORE: begin
        // Counter value 1 marks the final strobe cycle; the next edge completes.
        if (latCnt == LAT_ONE) begin
          nextState  = IDLE;
          accessDone = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign readM1  = (state == FETCH);
  assign readM2  = (state == LOAD);
  assign writeM2 = (state == STORE);
  assign busy    = (state != IDLE);
  assign data2   = writeM2 ? storeData : {WORD_SIZE{1'bz}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latCnt    <= '0;
      inst      <= '0;
      mdr       <= '0;
      num_fetch <= '0;
      address1  <= '0;
      address2  <= '0;
      storeData <= '0;
      done      <= 1'b0;
    end else begin
      done <= accessDone;
      if (state == IDLE) begin
        // Latch only the winning request; addresses otherwise hold their last value.
        if (nextState != IDLE) latCnt <= LAT_INIT;
        if (nextState == FETCH) address1 <= fetch_addr;
        if ((nextState == LOAD) || (nextState == STORE)) address2 <= data_addr;
        if (nextState == STORE) storeData <= store_data;
      end else begin
        latCnt <= latCnt - LAT_ONE;
        if (accessDone) begin
          if (state == FETCH) begin
            inst      <= data1;
            num_fetch <= num_fetch + CNT_WIDTH'(1);
          end
          if (state == LOAD) begin
            mdr <= data2;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_mem_access_unit.sv
module tb_mc_mem_access_unit;

  localparam int N = 4;  // instance k runs with MEM_LATENCY = k+1; instance 0 has a 4-bit fetch counter

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, fetch_req, load_req, store_req, memClr;
  logic [15:0] fetch_addr, data_addr, store_data;

  logic [15:0] instO [N];
  logic [15:0] mdrO  [N];
  logic [15:0] nfO   [N];
  logic [15:0] a1O   [N];
  logic [15:0] a2O   [N];
  logic [15:0] d1I   [N];
  logic [15:0] d2O   [N];
  logic [15:0] rdVal [N];
  logic        busyO [N];
  logic        doneO [N];
  logic        rM1   [N];
  logic        rM2   [N];
  logic        wM2   [N];

  // Physical data memory seen by each instance's data port.
  logic [15:0] pmem [N][256];
  logic        pval [N][256];

  function automatic logic [15:0] imemF(input logic [15:0] a);
    if (a == 16'h0010) return 16'h6A05;
    return (a * 16'h9E37) ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] dinitF(input logic [15:0] a);
    if (a[7:0] == 8'h23) return 16'hBEEF;
    return {a[7:0], ~a[7:0]} ^ 16'h5A5A;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = g + 1;
    localparam int CW  = (g == 0) ? 4 : 16;
    wire  [15:0]   d2;
    logic [CW-1:0] nf;

    mc_mem_access_unit #(
      .WORD_SIZE(16), .ADDR_WIDTH(16), .MEM_LATENCY(LAT), .CNT_WIDTH(CW)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .load_req(load_req), .store_req(store_req),
      .data_addr(data_addr), .store_data(store_data),
      .inst(instO[g]), .mdr(mdrO[g]), .busy(busyO[g]), .done(doneO[g]),
      .num_fetch(nf),
      .readM1(rM1[g]), .address1(a1O[g]), .data1(d1I[g]),
      .readM2(rM2[g]), .writeM2(wM2[g]), .address2(a2O[g]), .data2(d2)
    );

    assign nfO[g]   = 16'(nf);
    assign d2       = rM2[g] ? rdVal[g] : 16'hzzzz;
    assign d2O[g]   = d2;
    assign d1I[g]   = imemF(a1O[g]);
    assign rdVal[g] = pval[g][a2O[g][7:0]] ? pmem[g][a2O[g][7:0]] : dinitF(a2O[g]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (memClr) begin
        for (int i = 0; i < 256; i++) pval[k][i] <= 1'b0;
      end else if (wM2[k]) begin
        pmem[k][a2O[k][7:0]] <= d2O[k];
        pval[k][a2O[k][7:0]] <= 1'b1;
      end
    end
  end

  // Reference model: an access is described by its accept edge t0 and kind;
  // everything observable is derived from the cycle number relative to t0.
  int          lat  [N];
  int          cw   [N];
  bit          mAct [N];
  int          mT0  [N];
  int          mKind[N];   // 1 fetch, 2 load, 3 store
  logic [15:0] mA1  [N];
  logic [15:0] mA2  [N];
  logic [15:0] mSd  [N];
  logic [15:0] mInst[N];
  logic [15:0] mMdr [N];
  int          mNf  [N];
  int          mDoneCyc[N];
  logic [15:0] mMem [N][256];
  bit          mVal [N][256];
  int          cyc;
  bit          mValid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d(L=%0d) cycle %0d: got %h expected %h", nm, k, k + 1, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] mRead(input int k, input logic [15:0] a);
    return mVal[k][a[7:0]] ? mMem[k][a[7:0]] : dinitF(a);
  endfunction

  // Advance the model across the coming edge using the inputs now applied.
  task automatic modelEdge();
    int e;
    e = cyc + 1;
    for (int k = 0; k < N; k++) begin
      // The memory takes the write on every edge ending a strobe-high cycle.
      if (mAct[k] && mKind[k] == 3) begin
        mMem[k][mA2[k][7:0]] = mSd[k];
        mVal[k][mA2[k][7:0]] = 1'b1;
      end
      if (!reset_n) begin
        mAct[k] = 1'b0; mA1[k] = '0; mA2[k] = '0; mInst[k] = '0; mMdr[k] = '0;
        mNf[k] = 0; mDoneCyc[k] = -1;
      end else if (mAct[k]) begin
        if (e == mT0[k] + lat[k]) begin
          mAct[k] = 1'b0;
          mDoneCyc[k] = e;
          if (mKind[k] == 1) begin
            mInst[k] = imemF(mA1[k]);
            mNf[k] = (mNf[k] + 1) % (1 << cw[k]);
          end else if (mKind[k] == 2) begin
            mMdr[k] = mRead(k, mA2[k]);
          end
        end
      end else if (store_req) begin
        mAct[k] = 1'b1; mT0[k] = e; mKind[k] = 3; mA2[k] = data_addr; mSd[k] = store_data;
      end else if (load_req) begin
        mAct[k] = 1'b1; mT0[k] = e; mKind[k] = 2; mA2[k] = data_addr;
      end else if (fetch_req) begin
        mAct[k] = 1'b1; mT0[k] = e; mKind[k] = 1; mA1[k] = fetch_addr;
      end
    end
    if (!reset_n) mValid = 1'b1;
  endtask

  task automatic compareAll();
    if (!mValid) return;
    for (int k = 0; k < N; k++) begin
      chk("busy",      k, {15'b0, busyO[k]}, {15'b0, mAct[k]});
      chk("done",      k, {15'b0, doneO[k]}, {15'b0, (mDoneCyc[k] == cyc)});
      chk("readM1",    k, {15'b0, rM1[k]},   {15'b0, (mAct[k] && mKind[k] == 1)});
      chk("readM2",    k, {15'b0, rM2[k]},   {15'b0, (mAct[k] && mKind[k] == 2)});
      chk("writeM2",   k, {15'b0, wM2[k]},   {15'b0, (mAct[k] && mKind[k] == 3)});
      chk("inst",      k, instO[k], mInst[k]);
      chk("mdr",       k, mdrO[k],  mMdr[k]);
      chk("num_fetch", k, nfO[k],   16'(mNf[k]));
      chk("address1",  k, a1O[k],   mA1[k]);
      chk("address2",  k, a2O[k],   mA2[k]);
      if (mAct[k] && mKind[k] == 3) chk("data2", k, d2O[k], mSd[k]);
    end
  endtask

  task automatic cycle();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compareAll();
  endtask

  task automatic clearReqs();
    fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
  endtask

  int n;

  initial begin
    for (int k = 0; k < N; k++) begin
      lat[k] = k + 1;
      cw[k] = (k == 0) ? 4 : 16;
      mDoneCyc[k] = -1;
    end
    cyc = 0; mValid = 1'b0;
    reset_n = 1'b0; memClr = 1'b1;
    clearReqs();
    fetch_addr = '0; data_addr = '0; store_data = '0;

    @(negedge clk);
    cycle(); cycle();
    memClr = 1'b0; reset_n = 1'b1;
    chk("rst_num_fetch", 0, nfO[0], 16'h0000);
    chk("rst_busy",      3, {15'b0, busyO[3]}, 16'h0000);

    // Fetch at 0x0010, L=1 instance.
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    cycle();
    clearReqs();
    chk("f_readM1", 0, {15'b0, rM1[0]}, 16'h0001);
    chk("f_addr1",  0, a1O[0], 16'h0010);
    cycle();
    chk("f_inst",  0, instO[0], 16'h6A05);
    chk("f_done",  0, {15'b0, doneO[0]}, 16'h0001);
    chk("f_nf",    0, nfO[0], 16'h0001);
    chk("f_strobe_off", 0, {15'b0, rM1[0]}, 16'h0000);
    repeat (5) cycle();

    // Load from 0x0123, L=4 instance.
    load_req = 1'b1; data_addr = 16'h0123;
    cycle();
    clearReqs();
    n = int'(rM2[3]);
    repeat (3) begin cycle(); n += int'(rM2[3]); end
    cycle();
    chk("l_strobe_cycles", 3, 16'(n), 16'd4);
    chk("l_mdr",  3, mdrO[3], 16'hBEEF);
    chk("l_busy", 3, {15'b0, busyO[3]}, 16'h0000);
    chk("l_done", 3, {15'b0, doneO[3]}, 16'h0001);
    repeat (3) cycle();

    // Store 0x1234 to 0x0040, L=2 instance.
    store_req = 1'b1; data_addr = 16'h0040; store_data = 16'h1234;
    cycle();
    clearReqs();
    n = int'(wM2[1]);
    chk("s_data2", 1, d2O[1], 16'h1234);
    cycle(); n += int'(wM2[1]);
    cycle();
    chk("s_strobe_cycles", 1, 16'(n), 16'd2);
    chk("s_writeM2_off", 1, {15'b0, wM2[1]}, 16'h0000);
    chk("s_mdr_kept", 1, mdrO[1], 16'hBEEF);
    chk("s_mem", 1, pval[1][8'h40] ? pmem[1][8'h40] : 16'hFFFF, 16'h1234);
    repeat (4) cycle();

    // Simultaneous requests, then a fetch during busy, then one in the done cycle (L=4).
    store_req = 1'b1; load_req = 1'b1; fetch_req = 1'b1;
    data_addr = 16'h0050; store_data = 16'h0BAD; fetch_addr = 16'h0020;
    cycle();
    clearReqs();
    chk("p_write", 3, {15'b0, wM2[3]}, 16'h0001);
    chk("p_nofetch", 3, {15'b0, rM1[3]}, 16'h0000);
    chk("p_noload", 3, {15'b0, rM2[3]}, 16'h0000);
    fetch_req = 1'b1;
    cycle();
    clearReqs();
    cycle(); cycle(); cycle();
    chk("p_done", 3, {15'b0, doneO[3]}, 16'h0001);
    chk("p_nf_unchanged", 3, nfO[3], 16'h0001);
    fetch_req = 1'b1; fetch_addr = 16'h0020;
    cycle();
    clearReqs();
    chk("p_refetch", 3, {15'b0, rM1[3]}, 16'h0001);
    chk("p_refetch_addr", 3, a1O[3], 16'h0020);
    repeat (6) cycle();

    // Reset for two edges in the middle of a store (L=3 instance).
    store_req = 1'b1; data_addr = 16'h0060; store_data = 16'h7777;
    cycle();
    clearReqs();
    cycle();
    reset_n = 1'b0;
    cycle(); cycle();
    reset_n = 1'b1;
    chk("r_writeM2", 2, {15'b0, wM2[2]}, 16'h0000);
    chk("r_nf", 2, nfO[2], 16'h0000);
    chk("r_busy", 2, {15'b0, busyO[2]}, 16'h0000);
    repeat (4) begin
      cycle();
      chk("r_no_done", 2, {15'b0, doneO[2]}, 16'h0000);
    end

    // 17 back-to-back fetches on the 4-bit counter (L=1): wraps to 1.
    fetch_req = 1'b1; fetch_addr = 16'h0200;
    repeat (33) cycle();
    clearReqs();
    cycle();
    chk("w_nf_wrap", 0, nfO[0], 16'h0001);
    repeat (4) cycle();

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      store_req  = ($urandom_range(0, 5) == 0);
      load_req   = ($urandom_range(0, 4) == 0);
      fetch_req  = ($urandom_range(0, 2) == 0);
      fetch_addr = 16'($urandom);
      data_addr  = 16'($urandom);
      store_data = 16'($urandom);
      reset_n    = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset_n = 1'b1;
    clearReqs();
    repeat (5) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_mem_access_unit.md
Name: mc_mem_access_unit

Overview:
Parametrised memory-access sequencer for the multicycle CPU datapath. It takes single-cycle fetch/load/store requests from the control/datapath and drives the instruction port (readM1/address1/data1) and data port (readM2/writeM2/address2/data2) for a configurable memory latency. It latches the returned instruction and memory data, reports completion, and counts completed instruction fetches. Unlike the fixed one-cycle access in the current datapath, it supports multi-cycle memory with a busy/done handshake.

Parameters:
WORD_SIZE, 16, data width of inst, mdr, store_data, data1, data2
ADDR_WIDTH, 16, width of all addresses
MEM_LATENCY, 1, cycles a strobe stays high before data is valid or a write completes; legal 1..15; 0 is illegal and must trip a simulation assertion
CNT_WIDTH, 16, width of num_fetch

Ports:
clk  in  1  clock; all state updates on posedge
reset_n  in  1  synchronous active-low reset, sampled on posedge clk
fetch_req  in  1  request instruction fetch from fetch_addr
fetch_addr  in  ADDR_WIDTH  fetch address (PC)
load_req  in  1  request data load from data_addr
store_req  in  1  request data store of store_data to data_addr
data_addr  in  ADDR_WIDTH  load/store address (ALUOut)
store_data  in  WORD_SIZE  store value (B register)
inst  out  WORD_SIZE  last fetched instruction
mdr  out  WORD_SIZE  last loaded data word
busy  out  1  high while an access is in progress
done  out  1  one-cycle pulse after any access completes
num_fetch  out  CNT_WIDTH  count of completed fetches
readM1  out  1  instruction-port read strobe
address1  out  ADDR_WIDTH  instruction-port address
data1  in  WORD_SIZE  instruction-port read data
readM2  out  1  data-port read strobe
writeM2  out  1  data-port write strobe
address2  out  ADDR_WIDTH  data-port address
data2  inout  WORD_SIZE  data-port bus; driven only while writeM2=1, else high-Z

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; inst, mdr, num_fetch, address1, address2 = 0; readM1, readM2, writeM2, busy, done = 0; data2 high-Z; latency counter = 0. Reset mid-access aborts it: no capture, no done, no count increment.
- FSM states: IDLE, FETCH, LOAD, STORE.
- IDLE: requests are sampled at posedge. Priority is store > load > fetch. Lower-priority simultaneous requests are dropped, not queued; the requester must re-assert them. On acceptance, the request's address (and store_data) is latched, the counter is set to MEM_LATENCY, and the FSM moves to the matching state.
- FETCH/LOAD/STORE: the matching strobe is 1 and busy=1 for exactly MEM_LATENCY cycles, beginning the cycle after the accepting edge. The address stays stable and the counter decrements each edge.
- Completion happens at the edge where the counter reaches 1:
  - FETCH: inst <= data1 and num_fetch <= num_fetch+1 (wraps modulo 2^CNT_WIDTH).
  - LOAD: mdr <= data2.
  - STORE: nothing is captured.
  - In all three cases the strobe drops, the FSM returns to IDLE, and done=1 for the following cycle.
- done and IDLE coincide, so a request presented during the done cycle is accepted at the next edge. Back-to-back access period is MEM_LATENCY+1 cycles.
- Requests arriving while busy=1 are ignored entirely.
- For an accepted request at edge t0: the strobe is high for cycles t0..t0+L-1, data is captured at edge t0+L, and done is high in cycle t0+L.
- inst and mdr hold their values until the next completed fetch or load respectively.
- At most one of readM1, readM2, writeM2 is high in any cycle.
- While writeM2=1, data2 carries the latched store_data.
- address1 and address2 hold their last values when idle.

Test Plan:
- Reset: hold reset_n=0 for 2 edges mid-STORE (L=3) -> writeM2=0, data2=Z, done never pulses, num_fetch=0, state IDLE.
- Fetch, L=1: fetch_req with fetch_addr=0x0010 and data1=0x6A05 -> readM1=1 for 1 cycle with address1=0x0010; inst=0x6A05; done pulses 1 cycle; num_fetch=1.
- Load, L=4: load_req with data_addr=0x0123 and memory value 0xBEEF -> readM2 high exactly 4 cycles; mdr=0xBEEF at edge t0+4; busy low in the done cycle.
- Store, L=2: store_req with data_addr=0x0040 and store_data=0x1234 -> writeM2 high 2 cycles; data2=0x1234 only during them; memory[0x40]=0x1234; mdr unchanged.
- Priority/ignore: store_req, load_req and fetch_req together -> only STORE runs. A fetch_req pulsed during busy is dropped (num_fetch unchanged). Re-asserting it in the done cycle starts the fetch at the next edge.
- Wrap: CNT_WIDTH=4 with 17 fetches at L=1 -> num_fetch=1; each fetch takes 2 cycles back-to-back.
